// File: rtl/serial_link_pkg.sv
// Shared types and constants for the LSB-first serial word link.
// Optional feature macro: SERIALIZER_PARITY_EN (adds one even-parity bit per frame).
package serial_link_pkg;

    // Serializer FSM states; S_PARITY is only reachable with SERIALIZER_PARITY_EN.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_t;

    localparam int DEFAULT_LENGTH = 24;

    // Number of bits on the wire per frame for a given data length.
    function automatic int frame_bits(input int len);
`ifdef SERIALIZER_PARITY_EN
        return len + 1;
`else
        return len;
`endif
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: load, shift right, synchronous clear,
// all gated by a clock enable, with an asynchronous active-low clear.
// Priority when enabled: clear > load > shift.
module piso_shift_reg #(
    parameter int LENGTH = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [LENGTH-1:0] din,
    output logic [LENGTH-1:0] q
);

    // Register update: q[0] is always the bit currently on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            if (clear) begin
                q <= '0;
            end else if (load) begin
                q <= din;
            end else if (shift) begin
                q <= {1'b0, q[LENGTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: accepts a LENGTH-bit word and sends it
// LSB first, one bit per enabled clock, strobing o_dout_valid on the last
// bit of the frame.
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity bit
// (carrying the strobe) after the data bits.
//
// Handshake: a word is transferred at a rising edge where
// i_word_valid && o_word_ready. o_word_ready is combinational,
// (state==S_IDLE) && i_en, and never depends on i_word_valid; i_word is
// sampled only at that edge. i_word_valid while busy is ignored.
module word_serializer
    import serial_link_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [LENGTH-1:0] i_word,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_busy,
    output ser_state_t        dbg_state
);

    localparam int CNT_W      = $clog2(LENGTH + 1);
    localparam int FRAME_BITS = frame_bits(LENGTH);
    // Counter value while the strobed (final) bit of the frame is on the wire.
    // With parity the counter has stepped to LENGTH when S_PARITY is entered.
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(LENGTH - 1);

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              valid_q;
    logic              valid_nxt;
    logic              busy_q;
    logic              busy_nxt;
    logic              accept;
    logic              sr_load;
    logic              sr_shift;
    logic              sr_clear;
    logic [LENGTH-1:0] sr_din;
    logic [LENGTH-1:0] shreg;

    assign o_word_ready = (state == S_IDLE) && i_en;
    assign accept       = i_word_valid && o_word_ready;

`ifdef SERIALIZER_PARITY_EN
    logic par;

    // Even parity of the accepted word, held for the trailing parity bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^i_word;
        end
    end
`endif

    // Shift register; its bit 0 drives o_dout directly, so it is cleared
    // whenever the FSM returns to idle to keep the line low between frames.
    piso_shift_reg #(
        .LENGTH(LENGTH)
    ) u_shreg (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (i_en),
        .load  (sr_load),
        .shift (sr_shift),
        .clear (sr_clear),
        .din   (sr_din),
        .q     (shreg)
    );

    // Next-state, counter and shift-register control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_clear  = 1'b0;
        sr_din    = i_word;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    sr_load   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_en) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_DATA) begin
`ifdef SERIALIZER_PARITY_EN
                        // Replace the spent data with the parity bit at bit 0.
                        sr_load   = 1'b1;
                        sr_din    = {{(LENGTH-1){1'b0}}, par};
                        state_nxt = S_PARITY;
`else
                        sr_clear  = 1'b1;
                        state_nxt = S_IDLE;
`endif
                    end else begin
                        sr_shift = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (i_en) begin
                    sr_clear  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                sr_clear  = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt  = (state_nxt != S_IDLE);
        valid_nxt = (state_nxt != S_IDLE) && (cnt_nxt == LAST_CNT);
    end

    // State, counter and registered strobe/busy flags; all frozen when i_en is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (i_en) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            valid_q <= valid_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign o_dout       = shreg[0];
    assign o_dout_valid = valid_q;
    assign o_busy       = busy_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (LENGTH=24), queue-based reference
// model of the wire, plus directed scenarios and a randomized soak.
module tb_word_serializer;
    import serial_link_pkg::*;

    localparam int L = 24;
`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR  = 1'b1;
    localparam int SPAN = 25;
`else
    localparam bit PAR  = 1'b0;
    localparam int SPAN = 24;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         word_valid = 1'b0;
    logic [L-1:0] word = '0;
    logic         word_ready;
    logic         dout;
    logic         dout_valid;
    logic         busy;
    ser_state_t   dbg_state;

    word_serializer #(.LENGTH(L)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_word       (word),
        .i_word_valid (word_valid),
        .o_word_ready (word_ready),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_busy       (busy),
        .dbg_state    (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Reference model: every accepted word becomes a list of wire entries
    // {is_parity, strobe, bit}; one entry is consumed per enabled edge.
    logic [2:0]   exp_q[$];
    logic [L-1:0] word_q[$];
    logic         m_dout, m_valid, m_busy;
    int           m_pos;
    bit           accepted, new_data, par_popped;
    logic [L-1:0] rx, last_rx;
    logic         last_par, last_par_valid;
    int           busy_run, last_run, cyc, acc_last, acc_prev;

    task automatic model_reset();
        exp_q.delete();
        word_q.delete();
        m_dout = 0; m_valid = 0; m_busy = 0; m_pos = 0;
        accepted = 0; new_data = 0; par_popped = 0;
        rx = '0; busy_run = 0;
    endtask

    task automatic model_step();
        logic [2:0] e;
        accepted = 0; new_data = 0; par_popped = 0;
        if (!en) return;
        if (!m_busy && word_valid) begin
            for (int i = 0; i < L; i++)
                exp_q.push_back({1'b0, ((i == L-1) && !PAR), word[i]});
            if (PAR) exp_q.push_back({1'b1, 1'b1, ^word});
            word_q.push_back(word);
            accepted = 1;
            m_pos = -1;
        end
        if (m_busy || accepted) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_dout = e[0]; m_valid = e[1]; m_busy = 1;
                m_pos++;
                new_data = !e[2];
                par_popped = e[2];
            end else begin
                m_dout = 0; m_valid = 0; m_busy = 0;
            end
        end
    endtask

    // Scoreboard / compare process: step the model at the edge, sample 1 ns later.
    always @(posedge clk) begin
        if (rst_n) model_step();
        else begin accepted = 0; new_data = 0; par_popped = 0; end
        cyc++;
        if (accepted) begin acc_prev = acc_last; acc_last = cyc; end
        #1;
        check("dout", dout, m_dout);
        check("dout_valid", dout_valid, m_valid);
        check("busy", busy, m_busy);
        check("word_ready", word_ready, !m_busy && en);
        if (new_data) begin
            rx = {dout, rx[L-1:1]};
            if (m_pos == L-1) begin
                last_rx = rx;
                if (word_q.size() > 0) check("loopback", rx, word_q.pop_front());
            end
        end
        if (par_popped) begin last_par = dout; last_par_valid = dout_valid; end
        if (busy) busy_run++;
        else if (busy_run > 0) begin last_run = busy_run; busy_run = 0; end
    end

    // Driver tasks
    task automatic send(input logic [L-1:0] w);
        int budget;
        @(negedge clk);
        word = w; word_valid = 1;
        budget = 200;
        do begin @(posedge clk); #2; budget--; end while (!accepted && budget > 0);
        if (!accepted) timeout("send_accept");
        @(negedge clk);
        word_valid = 0;
        word = L'($urandom);
    endtask

    task automatic wait_idle();
        int budget = 300;
        while ((m_busy || exp_q.size() > 0) && budget > 0) begin @(posedge clk); #2; budget--; end
        if (budget == 0) timeout("wait_idle");
        @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        int budget = 300;
        while (!(m_busy && m_pos == p) && budget > 0) begin @(posedge clk); #2; budget--; end
        if (budget == 0) timeout("wait_pos");
    endtask

    initial begin
        int budget;
        model_reset();
        cyc = 0; acc_last = 0; acc_prev = 0; last_run = 0;
        last_par = 0; last_par_valid = 0; last_rx = '0;

        // 1. reset held for 3 cycles
        rst_n = 0; en = 1;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready_en1", word_ready, 1);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        en = 0; #1;
        check("rst_ready_en0", word_ready, 0);
        en = 1;
        rst_n = 1;

        // 2. basic frame
        send(24'hA5C3F1);
        wait_idle();
        check("t2_word", last_rx, 24'hA5C3F1);
        check("t2_first8", last_rx[7:0], 8'hF1);
        check("t2_span", last_run, SPAN);

        // 3. stall while bit 10 is on the wire (bit 10 of 0x3C0F96 is 1)
        send(24'h3C0F96);
        wait_pos(10);
        @(negedge clk); en = 0;
        repeat (3) @(negedge clk);
        check("t3_hold_bit", dout, 1);
        check("t3_hold_busy", busy, 1);
        en = 1;
        wait_idle();
        check("t3_word", last_rx, 24'h3C0F96);
        check("t3_span", last_run, SPAN + 3);

        // 4. word offered while busy is ignored, then taken on the first ready cycle
        send(24'hC0FFEE);
        @(negedge clk);
        word = 24'h123456; word_valid = 1;
        #1;
        check("t4_ready_busy", word_ready, 0);
        budget = 200;
        do begin @(posedge clk); #2; budget--; end while (!accepted && budget > 0);
        if (!accepted) timeout("t4_accept");
        check("t4_accept_gap", acc_last - acc_prev, SPAN + 1);
        @(negedge clk); word_valid = 0;
        wait_idle();
        check("t4_word", last_rx, 24'h123456);

        // 5. reset mid-frame
        send(24'h0F0F0F);
        wait_pos(12);
        @(negedge clk);
        #3 rst_n = 0;
        model_reset();
        #1;
        check("t5_dout", dout, 0);
        check("t5_valid", dout_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clk); rst_n = 1;
        send(24'hFFFFFF);
        wait_idle();
        check("t5_word", last_rx, 24'hFFFFFF);
        check("t5_span", last_run, SPAN);

`ifdef SERIALIZER_PARITY_EN
        // 6. parity bit of 0x000007 is 1 and carries the strobe
        send(24'h000007);
        wait_idle();
        check("t6_word", last_rx, 24'h000007);
        check("t6_par_bit", last_par, 1);
        check("t6_par_strobe", last_par_valid, 1);
`endif

        // Randomized soak: random enable, random offers, random data
        repeat (800) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
            word_valid = $urandom_range(0, 1);
            word = L'($urandom);
        end
        @(negedge clk);
        en = 1; word_valid = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
